nf_run_ctrl: RTL and testbench

Run-control sequencer for the nanoFOX CPU core, sitting between the top level and `nf_cpu`. Generates the `cpu_en` instruction-step strobe from a programmable clock divider and sequences the core through run, halt, single-step and PC-breakpoint stop. Maintains the retired-step counter used by debug logging.

---
 rtl/nf_ctrl_pkg.sv | 36 +++
 rtl/nf_en_div.sv | 40 ++++
 rtl/nf_run_ctrl.sv | 135 +++++++++++++
 tb/tb_nf_run_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nf_ctrl_pkg.sv
// Shared run-control definitions for nanoFOX: sequencer states and command
// encoding, where a higher command code always wins when pulses coincide.
package nf_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } run_state_t;

    // Encoded value doubles as priority: halt > step > run > none.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_HALT = 2'd3
    } run_cmd_t;

    function automatic run_cmd_t cmd_decode(
        input logic halt_pulse,
        input logic step_pulse,
        input logic run_pulse
    );
        run_cmd_t cmd;
        cmd = CMD_NONE;
        if (halt_pulse) begin
            cmd = CMD_HALT;
        end else if (step_pulse) begin
            cmd = CMD_STEP;
        end else if (run_pulse) begin
            cmd = CMD_RUN;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/nf_en_div.sv
// Programmable strobe divider: ticks once every div+1 enabled clocks.
// The count is forced to zero whenever disabled or explicitly cleared.
module nf_en_div #(
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;

    // >= rather than == so that lowering div below the running count
    // produces a tick straight away instead of waiting for a wrap.
    assign tick = en && (cnt_reg >= div);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr || !en) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/nf_run_ctrl.sv
// Run-control sequencer for nf_cpu: issues cpu_en strobes and handles
// run / halt / single-step and PC breakpoint stops.
module nf_run_ctrl
    import nf_ctrl_pkg::*;
#(
    parameter int DIV_W     = 26,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 32,
    parameter bit START_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DIV_W-1:0]  div,
    input  logic              cmd_run,
    input  logic              cmd_halt,
    input  logic              cmd_step,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic              step_done,
    output logic [CNT_W-1:0]  cycle_counter
);

    localparam run_state_t RESET_STATE = START_RUN ? RUN : HALT;

    run_state_t       state_reg;
    run_state_t       state_next;
    logic             armed_reg;
    logic             skip_bp_reg;
    logic             skip_bp_next;
    logic             bp_hit_reg;
    logic             bp_hit_next;
    logic             step_done_reg;
    logic             step_done_next;
    logic [CNT_W-1:0] cycle_counter_reg;

    logic             div_en;
    logic             div_clr;
    logic             div_tick;
    logic             bp_match;
    logic             bp_stop;
    logic             strobe;
    run_cmd_t         cmd;

    // armed_reg holds the divider at zero until the first edge after reset,
    // so a START_RUN core counts its first period from that edge.
    assign div_en  = (state_reg != HALT) && armed_reg;
    assign div_clr = (state_next != state_reg);

    nf_en_div #(
        .DIV_W (DIV_W)
    ) u_en_div (
        .clk    (clk),
        .resetn (resetn),
        .en     (div_en),
        .clr    (div_clr),
        .div    (div),
        .tick   (div_tick)
    );

    assign bp_match = bp_en && (instr_addr == bp_addr) && !skip_bp_reg;
    assign bp_stop  = div_tick && (state_reg == RUN) && bp_match;
    assign strobe   = div_tick && !bp_stop;
    assign cmd      = cmd_decode(cmd_halt, cmd_step, cmd_run);

    always_comb begin
        state_next     = state_reg;
        skip_bp_next   = skip_bp_reg;
        bp_hit_next    = bp_stop;
        step_done_next = 1'b0;

        // An executed instruction re-arms breakpoint matching.
        if (strobe) begin
            skip_bp_next = 1'b0;
        end

        case (state_reg)
            HALT: begin
                if (cmd == CMD_STEP) begin
                    state_next   = STEP;
                    skip_bp_next = 1'b1;
                end else if (cmd == CMD_RUN) begin
                    state_next   = RUN;
                    skip_bp_next = 1'b1;
                end
            end
            RUN: begin
                if (cmd == CMD_HALT || bp_stop) begin
                    state_next = HALT;
                end
            end
            STEP: begin
                if (div_tick) begin
                    state_next     = HALT;
                    step_done_next = 1'b1;
                end else if (cmd == CMD_HALT) begin
                    state_next = HALT;
                end
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= RESET_STATE;
            armed_reg         <= 1'b0;
            skip_bp_reg       <= 1'b1;
            bp_hit_reg        <= 1'b0;
            step_done_reg     <= 1'b0;
            cycle_counter_reg <= '0;
        end else begin
            state_reg     <= state_next;
            armed_reg     <= 1'b1;
            skip_bp_reg   <= skip_bp_next;
            bp_hit_reg    <= bp_hit_next;
            step_done_reg <= step_done_next;
            if (strobe) begin
                cycle_counter_reg <= cycle_counter_reg + 1'b1;
            end
        end
    end

    assign cpu_en        = strobe;
    assign halted        = (state_reg == HALT);
    assign bp_hit        = bp_hit_reg;
    assign step_done     = step_done_reg;
    assign cycle_counter = cycle_counter_reg;

endmodule

// File: tb/tb_nf_run_ctrl.sv
// Directed bench for nf_run_ctrl: hand-computed strobe timing for run, halt,
// step, breakpoint stop/resume, command priority and mid-count div changes.
module tb_nf_run_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [25:0] div = 26'd3;
    logic        cmd_run = 1'b0;
    logic        cmd_halt = 1'b0;
    logic        cmd_step = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc;
    logic        pc_load = 1'b1;
    logic [31:0] pc_load_val = 32'h0;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic        step_done;
    logic [31:0] cycle_counter;

    int n_checks = 0;
    int n_fail = 0;

    nf_run_ctrl #(
        .DIV_W     (26),
        .ADDR_W    (32),
        .CNT_W     (32),
        .START_RUN (1'b1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .div           (div),
        .cmd_run       (cmd_run),
        .cmd_halt      (cmd_halt),
        .cmd_step      (cmd_step),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .instr_addr    (pc),
        .cpu_en        (cpu_en),
        .halted        (halted),
        .bp_hit        (bp_hit),
        .step_done     (step_done),
        .cycle_counter (cycle_counter)
    );

    always #5 clk = ~clk;

    // Minimal CPU model: PC advances by one word per cpu_en strobe.
    always @(posedge clk) begin
        if (pc_load) begin
            pc <= pc_load_val;
        end else if (cpu_en) begin
            pc <= pc + 32'd4;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance into the next cycle; inputs driven and outputs sampled here.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #12;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_halted", halted, 0);
        check("rst_counter", cycle_counter, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_step_done", step_done, 0);

        // Free run from reset, div = 3: strobes in cycles 3, 7, 11
        @(negedge clk);
        resetn  = 1'b1;
        pc_load = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            nxt();
            check($sformatf("run_en_c%0d", c), cpu_en, (c % 4 == 3));
            if (c == 12) check("run_counter", cycle_counter, 3);
        end

        // Halt sampled at the edge opening tick cycle 15
        nxt();
        check("pre_halt_en_c13", cpu_en, 0);
        nxt();
        cmd_halt = 1'b1;
        check("pre_halt_en_c14", cpu_en, 0);
        nxt();
        cmd_halt = 1'b0;
        check("halt_tick_suppressed", cpu_en, 0);
        check("halt_halted", halted, 1);
        check("halt_counter", cycle_counter, 3);
        for (int i = 0; i < 4; i++) begin
            nxt();
            check($sformatf("halt_quiet_%0d", i), cpu_en, 0);
        end

        // Single step, div = 2: strobe at index 2, step_done at index 3
        div = 26'd2;
        nxt();
        cmd_step = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            nxt();
            cmd_step = 1'b0;
            check($sformatf("step_en_%0d", i), cpu_en, (i == 2));
            check($sformatf("step_done_%0d", i), step_done, (i == 3));
            check($sformatf("step_halted_%0d", i), halted, (i >= 3));
            if (i == 3) check("step_counter", cycle_counter, 4);
        end

        // Breakpoint at 0x10, run from 0x8 with div = 1: stop at index 5
        div = 26'd1;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        nxt();
        pc_load = 1'b1;
        pc_load_val = 32'h8;
        cmd_run = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            nxt();
            pc_load = 1'b0;
            cmd_run = 1'b0;
            check($sformatf("bp_en_%0d", i), cpu_en, (i == 1 || i == 3));
            check($sformatf("bp_hit_%0d", i), bp_hit, (i == 6));
            check($sformatf("bp_halted_%0d", i), halted, (i == 6));
            if (i == 6) check("bp_counter", cycle_counter, 6);
        end

        // Step over the breakpoint instruction
        nxt();
        cmd_step = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            nxt();
            cmd_step = 1'b0;
            check($sformatf("bpstep_en_%0d", i), cpu_en, (i == 1));
            check($sformatf("bpstep_done_%0d", i), step_done, (i == 2));
            check($sformatf("bpstep_hit_%0d", i), bp_hit, 0);
            if (i == 2) check("bpstep_counter", cycle_counter, 7);
        end

        // Run resumed at the breakpoint PC executes it without re-hitting
        nxt();
        pc_load = 1'b1;
        pc_load_val = 32'h10;
        cmd_run = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            nxt();
            pc_load = 1'b0;
            cmd_run = 1'b0;
            check($sformatf("resume_en_%0d", i), cpu_en, (i == 1 || i == 3));
            check($sformatf("resume_hit_%0d", i), bp_hit, 0);
            check($sformatf("resume_halted_%0d", i), halted, 0);
            if (i == 4) check("resume_counter", cycle_counter, 9);
        end

        // All three commands together in RUN (index 5 is a tick cycle)
        nxt();
        check("prio_tick_en", cpu_en, 1);
        cmd_halt = 1'b1;
        cmd_step = 1'b1;
        cmd_run  = 1'b1;
        for (int j = 0; j <= 4; j++) begin
            nxt();
            cmd_halt = 1'b0;
            cmd_step = 1'b0;
            cmd_run  = 1'b0;
            check($sformatf("prio_en_%0d", j), cpu_en, 0);
            check($sformatf("prio_halted_%0d", j), halted, 1);
            check($sformatf("prio_step_done_%0d", j), step_done, 0);
            if (j == 4) check("prio_counter", cycle_counter, 10);
        end

        // div 10 -> 2 at the edge leaving cnt = 6: tick at 7, then every 3
        div = 26'd10;
        nxt();
        cmd_run = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            nxt();
            cmd_run = 1'b0;
            if (i == 7) begin
                div = 26'd2;
                #1;
            end
            check($sformatf("divchg_en_%0d", i), cpu_en, (i == 7 || i == 10 || i == 13));
            if (i == 11) check("divchg_counter", cycle_counter, 12);
        end

        // Asynchronous reset mid-run
        #1;
        resetn = 1'b0;
        #1;
        check("areset_counter", cycle_counter, 0);
        check("areset_halted", halted, 0);
        check("areset_cpu_en", cpu_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
